line_sensor_adc_reader: RTL and testbench

- Upstream stage of the line-follower motor/turn controller.
- Drives an ADC128S022-style SPI ADC. Round-robins the left, center and right IR channels.
- Presents registered 12-bit readings as left_sensor / center_sensor / right_sensor, plus thresholded line bits.
- Free-runs while en is high. sample_valid marks the completion of each full three-channel sweep.

---
 rtl/line_sensor_adc_reader.sv | 184 ++++++++++++++++++
 tb/tb_line_sensor_adc_reader.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_adc_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : line_sensor_adc_reader
// Brief    : Round-robin SPI reader for an ADC128S022-style ADC sampling the
//            left/center/right IR line sensors, with thresholded line bits.
// Revision : 1.0
// ============================================================================
module line_sensor_adc_reader #(
    parameter int unsigned CLK_DIV     = 16,
    parameter logic [2:0]  LEFT_CH     = 3'd0,
    parameter logic [2:0]  CENTER_CH   = 3'd1,
    parameter logic [2:0]  RIGHT_CH    = 3'd2,
    parameter logic [11:0] LINE_THRESH = 12'd500
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        adc_dout,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic        adc_din,
    output logic [11:0] left_sensor,
    output logic [11:0] center_sensor,
    output logic [11:0] right_sensor,
    output logic [2:0]  line_bits,
    output logic        sample_valid
);
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam logic [1:0]  IDX_L = 2'd0;
    localparam logic [1:0]  IDX_C = 2'd1;
    localparam logic [1:0]  IDX_R = 2'd2;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CS_SETUP = 2'd1,
        SHIFT    = 2'd2,
        CS_HOLD  = 2'd3
    } state_t;

    state_t           state_q;
    logic [DIV_W-1:0] div_cnt_q;
    logic [3:0]       bit_cnt_q;
    logic             half_q;
    logic [11:0]      shift_q;
    logic [1:0]       addr_idx_q;
    logic [1:0]       res_idx_q;
    logic             primed_q;
    logic             cs_n_q;
    logic             sclk_q;
    logic             din_q;
    logic [11:0]      left_q;
    logic [11:0]      center_q;
    logic [11:0]      right_q;
    logic [2:0]       line_q;
    logic             valid_q;

    logic [1:0]       addr_idx_d;
    logic [2:0]       cur_addr;
    logic [15:0]      frame_din;
    logic             div_last;

    always_comb begin
        case (addr_idx_q)
            IDX_C:   cur_addr = CENTER_CH;
            IDX_R:   cur_addr = RIGHT_CH;
            default: cur_addr = LEFT_CH;
        endcase
        addr_idx_d = (addr_idx_q == IDX_R) ? IDX_L : addr_idx_q + 2'd1;
        frame_din  = {2'b00, cur_addr, 11'b0};
    end

    assign div_last = (div_cnt_q == DIV_W'(CLK_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            bit_cnt_q  <= 4'd0;
            half_q     <= 1'b0;
            shift_q    <= 12'd0;
            addr_idx_q <= IDX_L;
            res_idx_q  <= IDX_L;
            primed_q   <= 1'b0;
            cs_n_q     <= 1'b1;
            sclk_q     <= 1'b1;
            din_q      <= 1'b0;
            left_q     <= 12'd0;
            center_q   <= 12'd0;
            right_q    <= 12'd0;
            line_q     <= 3'b000;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    div_cnt_q <= '0;
                    if (en) begin
                        state_q <= CS_SETUP;
                        cs_n_q  <= 1'b0;
                    end else begin
                        primed_q   <= 1'b0;
                        addr_idx_q <= IDX_L;
                    end
                end
                CS_SETUP: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        state_q   <= SHIFT;
                        sclk_q    <= 1'b0;
                        din_q     <= frame_din[15];
                        bit_cnt_q <= 4'd0;
                        half_q    <= 1'b0;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_last) begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end else begin
                        div_cnt_q <= '0;
                        if (!half_q) begin
                            // ADC data is sampled on the edge that raises SCLK
                            sclk_q  <= 1'b1;
                            half_q  <= 1'b1;
                            shift_q <= {shift_q[10:0], adc_dout};
                        end else if (bit_cnt_q == 4'd15) begin
                            state_q    <= CS_HOLD;
                            cs_n_q     <= 1'b1;
                            sclk_q     <= 1'b1;
                            din_q      <= 1'b0;
                            primed_q   <= 1'b1;
                            res_idx_q  <= addr_idx_q;
                            addr_idx_q <= addr_idx_d;
                            // Result belongs to the address sent in the previous frame
                            if (primed_q) begin
                                case (res_idx_q)
                                    IDX_L: begin
                                        left_q    <= shift_q;
                                        line_q[2] <= (shift_q > LINE_THRESH);
                                    end
                                    IDX_C: begin
                                        center_q  <= shift_q;
                                        line_q[1] <= (shift_q > LINE_THRESH);
                                    end
                                    default: begin
                                        right_q   <= shift_q;
                                        line_q[0] <= (shift_q > LINE_THRESH);
                                        valid_q   <= 1'b1;
                                    end
                                endcase
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                            half_q    <= 1'b0;
                            sclk_q    <= 1'b0;
                            din_q     <= frame_din[4'd14 - bit_cnt_q];
                        end
                    end
                end
                default: begin
                    if (div_last) begin
                        div_cnt_q <= '0;
                        state_q   <= IDLE;
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign adc_cs_n      = cs_n_q;
    assign adc_sclk      = sclk_q;
    assign adc_din       = din_q;
    assign left_sensor   = left_q;
    assign center_sensor = center_q;
    assign right_sensor  = right_q;
    assign line_bits     = line_q;
    assign sample_valid  = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sensor_adc_reader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_line_sensor_adc_reader
// Brief    : Self-checking bench with an ADC model and a commit scoreboard.
// Revision : 1.0
// ============================================================================
module tb_line_sensor_adc_reader;
    localparam int          CLK_DIV = 4;
    localparam logic [2:0]  L_CH    = 3'd0;
    localparam logic [2:0]  C_CH    = 3'd1;
    localparam logic [2:0]  R_CH    = 3'd2;
    localparam logic [11:0] THRESH  = 12'd500;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        adc_dout = 1'b0;
    logic        adc_cs_n, adc_sclk, adc_din;
    logic [11:0] left_sensor, center_sensor, right_sensor;
    logic [2:0]  line_bits;
    logic        sample_valid;

    line_sensor_adc_reader #(
        .CLK_DIV     (CLK_DIV),
        .LEFT_CH     (L_CH),
        .CENTER_CH   (C_CH),
        .RIGHT_CH    (R_CH),
        .LINE_THRESH (THRESH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .adc_dout      (adc_dout),
        .adc_cs_n      (adc_cs_n),
        .adc_sclk      (adc_sclk),
        .adc_din       (adc_din),
        .left_sensor   (left_sensor),
        .center_sensor (center_sensor),
        .right_sensor  (right_sensor),
        .line_bits     (line_bits),
        .sample_valid  (sample_valid)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [2:0]  addr;
        logic [11:0] val;
    } exp_t;

    exp_t        sb_q[$];
    logic [11:0] ch_val [0:7];
    logic        prev_cs = 1'b1, prev_sclk = 1'b1;
    int          bitk = 16, rise_cnt = 0, cs_low = 0, cyc = 0, last_fall = 0;
    bit          last_fall_ok = 1'b0;
    int          frame_idx = 0, frame_end_cnt = 0, sv_cnt = 0;
    bit          restart_flag = 1'b1, abort_flag = 1'b0;
    logic [2:0]  rx_addr = 3'd0, prev_rx_addr = 3'd0;
    logic [15:0] tx_frame = 16'd0;
    logic [11:0] exp_l = 12'd0, exp_c = 12'd0, exp_r = 12'd0;
    logic        exp_sv;

    function automatic logic [2:0] exp_addr(input int idx);
        case (idx % 3)
            0:       return L_CH;
            1:       return C_CH;
            default: return R_CH;
        endcase
    endfunction

    // ADC model and scoreboard: everything sampled mid-cycle on the falling clk edge
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        exp_sv = 1'b0;
        if (prev_cs && !adc_cs_n) begin
            if (restart_flag) begin
                frame_idx    = 0;
                restart_flag = 1'b0;
                last_fall_ok = 1'b0;
            end else begin
                frame_idx++;
            end
            if (last_fall_ok) check("frame_period", cyc - last_fall, 34 * CLK_DIV + 1);
            last_fall    = cyc;
            last_fall_ok = 1'b1;
            bitk     = 0;
            rise_cnt = 0;
            cs_low   = 0;
            rx_addr  = 3'd0;
            tx_frame = {4'h0, (frame_idx == 0) ? 12'hFFF : ch_val[prev_rx_addr]};
            if (frame_idx >= 1) sb_q.push_back({prev_rx_addr, tx_frame[11:0]});
        end
        if (!adc_cs_n) cs_low++;
        if (!adc_cs_n && prev_sclk && !adc_sclk && bitk < 16) adc_dout = tx_frame[15 - bitk];
        if (!adc_cs_n && !prev_sclk && adc_sclk) begin
            if (bitk >= 2 && bitk <= 4) rx_addr = {rx_addr[1:0], adc_din};
            bitk++;
            rise_cnt++;
        end
        if (!prev_cs && adc_cs_n) begin
            if (abort_flag) begin
                abort_flag   = 1'b0;
                restart_flag = 1'b1;
                last_fall_ok = 1'b0;
                sb_q.delete();
                exp_l = 12'd0;
                exp_c = 12'd0;
                exp_r = 12'd0;
            end else begin
                frame_end_cnt++;
                check("cs_low_cycles", cs_low, 33 * CLK_DIV);
                check("sclk_rises", rise_cnt, 16);
                check("frame_addr", rx_addr, exp_addr(frame_idx));
                prev_rx_addr = rx_addr;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    if (e.addr == L_CH) exp_l = e.val;
                    else if (e.addr == C_CH) exp_c = e.val;
                    else if (e.addr == R_CH) exp_r = e.val;
                    exp_sv = (e.addr == R_CH);
                end
                check("left_sensor", left_sensor, exp_l);
                check("center_sensor", center_sensor, exp_c);
                check("right_sensor", right_sensor, exp_r);
                check("line_bits", line_bits, {exp_l > THRESH, exp_c > THRESH, exp_r > THRESH});
            end
        end
        if (sample_valid === 1'b1) sv_cnt++;
        check("sample_valid", sample_valid, exp_sv);
        if (adc_cs_n) check("sclk_idle_high", adc_sclk, 1);
        prev_cs   = adc_cs_n;
        prev_sclk = adc_sclk;
    end

    task automatic wait_frames(input int n);
        int target;
        int k;
        target = frame_end_cnt + n;
        k = 0;
        while (frame_end_cnt < target && k < n * 200 + 200) begin
            @(posedge clk);
            k++;
        end
        if (frame_end_cnt < target) check("wait_frames_timeout", frame_end_cnt, target);
        #1;
    endtask

    task automatic wait_sv(input int n, input int max_cyc);
        int target;
        int k;
        target = sv_cnt + n;
        k = 0;
        while (sv_cnt < target && k < max_cyc) begin
            @(posedge clk);
            k++;
        end
        if (sv_cnt < target) check("wait_sv_timeout", sv_cnt, target);
        #1;
    endtask

    task automatic wait_bit(input int min_idx, input int b);
        int k;
        k = 0;
        while (!(frame_idx >= min_idx && bitk == b && !adc_cs_n) && k < 2000) begin
            @(posedge clk);
            k++;
        end
        if (k >= 2000) check("wait_bit_timeout", k, 0);
    endtask

    task automatic check_idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            check("idle_cs_n", adc_cs_n, 1);
        end
    endtask

    typedef struct {
        logic [11:0] l, c, r;
        logic [2:0]  lb;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int base;
        int pick;
        vecs[0] = '{12'h000, 12'hFFF, 12'h1F5, 3'b011};
        vecs[1] = '{12'h1F4, 12'h1F4, 12'h1F4, 3'b000};
        vecs[2] = '{12'h1F5, 12'h000, 12'h800, 3'b101};
        vecs[3] = '{12'hFFF, 12'h1F5, 12'h1F3, 3'b110};
        vecs[4] = '{12'h001, 12'h200, 12'hFFE, 3'b011};
        for (int i = 0; i < 8; i++) ch_val[i] = 12'd0;

        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_sclk", adc_sclk, 1);
        check("rst_din", adc_din, 0);
        check("rst_left", left_sensor, 0);
        check("rst_line_bits", line_bits, 0);
        check("rst_sample_valid", sample_valid, 0);

        // Priming frame returns 0xFFF, then the three channel values
        @(negedge clk);
        rst = 1'b0;
        ch_val[L_CH] = 12'hABC;
        ch_val[C_CH] = 12'h1F4;
        ch_val[R_CH] = 12'h1F5;
        en = 1'b1;
        wait_sv(1, 6 * 137 + 50);
        check("first_sv_frame", frame_end_cnt, 4);
        check("t1_left", left_sensor, 12'hABC);
        check("t1_center", center_sensor, 12'h1F4);
        check("t1_right", right_sensor, 12'h1F5);
        check("t1_line_bits", line_bits, 3'b101);

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            ch_val[L_CH] = vecs[v].l;
            ch_val[C_CH] = vecs[v].c;
            ch_val[R_CH] = vecs[v].r;
            wait_sv(2, 8 * 137);
            check("vec_left", left_sensor, vecs[v].l);
            check("vec_center", center_sensor, vecs[v].c);
            check("vec_right", right_sensor, vecs[v].r);
            check("vec_line_bits", line_bits, vecs[v].lb);
        end

        // en drop: idle, re-prime, then drop again in frame 3's SHIFT
        wait_bit(0, 3);
        @(negedge clk);
        en = 1'b0;
        wait_frames(1);
        check_idle(100);
        @(negedge clk);
        restart_flag = 1'b1;
        en = 1'b1;
        wait_bit(2, 8);
        @(negedge clk);
        en = 1'b0;
        wait_frames(1);
        check("en_drop_center", center_sensor, ch_val[C_CH]);
        check_idle(100);
        @(negedge clk);
        restart_flag = 1'b1;
        en = 1'b1;
        wait_frames(1);
        check("reprime_center_held", center_sensor, ch_val[C_CH]);
        wait_sv(1, 6 * 137);

        // Reset during SCLK bit 7
        wait_bit(1, 7);
        @(negedge clk);
        abort_flag = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cs_n", adc_cs_n, 1);
        check("midrst_sclk", adc_sclk, 1);
        check("midrst_left", left_sensor, 0);
        check("midrst_center", center_sensor, 0);
        check("midrst_right", right_sensor, 0);
        check("midrst_line_bits", line_bits, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_sv(1, 6 * 137 + 50);
        check("sv_frames_after_rst", frame_idx + 1, 4);

        // Steady sweep with changing values, biased toward the threshold
        base = sv_cnt;
        for (int f = 0; f < 30; f++) begin
            @(negedge clk);
            pick = $urandom_range(0, 5);
            if (pick == 0)      ch_val[$urandom_range(0, 2)] = 12'd500;
            else if (pick == 1) ch_val[$urandom_range(0, 2)] = 12'd501;
            else                ch_val[$urandom_range(0, 2)] = 12'($urandom_range(0, 4095));
            wait_frames(1);
        end
        check("sweep_sv_count", sv_cnt - base, 10);

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
